// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage and the icache.
interface fetch_stage_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;

  modport master (output iREN, output iaddr, input ihit, input iload);
  modport slave  (input iREN, input iaddr, output ihit, output iload);
endinterface

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register. Owns the PC, drives icache reads and
// keeps a one-entry hold buffer so a word returned while the pipe is blocked
// is never requested twice.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          pc_en,
  input  logic          stall_ifid,
  input  logic          flush_ifid,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  fetch_stage_if.master ibus,
  output logic          ifid_valid,
  output logic [31:0]   ifid_instr,
  output logic [31:0]   ifid_pc,
  output logic [31:0]   ifid_npc
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic        ren;

  logic        got_word;
  logic        avail;
  logic [31:0] word;
  logic [31:0] pc_plus4;

  assign ibus.iREN  = ren;
  assign ibus.iaddr = pc;

  // Decode what the current cycle can offer to ID: a fresh hit or the held word.
  always_comb begin
    got_word = (state == FETCH) && ibus.ihit;
    avail    = got_word || (state == HOLD);
    word     = (state == HOLD) ? hold_buf : ibus.iload;
    pc_plus4 = pc + 32'd4;
  end

  // PC, hold buffer, fetch FSM and IF/ID register, in hazard-priority order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= PC_RESET;
      state      <= FETCH;
      ren        <= 1'b1;
      hold_buf   <= 32'h0;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 32'h0;
      ifid_npc   <= 32'h0;
    end else if (state != HALTED) begin
      if (redirect_valid) begin
        pc         <= redirect_pc & 32'hFFFF_FFFC;
        state      <= FETCH;
        ren        <= 1'b1;
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else if (halt) begin
        state      <= HALTED;
        ren        <= 1'b0;
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else if (flush_ifid || stall_ifid || !pc_en) begin
        if (flush_ifid) begin
          ifid_valid <= 1'b0;
          ifid_instr <= NOP_INSTR;
        end
        if (got_word) begin
          hold_buf <= ibus.iload;
          state    <= HOLD;
          ren      <= 1'b0;
        end
      end else if (avail) begin
        ifid_valid <= 1'b1;
        ifid_instr <= word;
        ifid_pc    <= pc;
        ifid_npc   <= pc_plus4;
        pc         <= pc_plus4;
        state      <= FETCH;
        ren        <= 1'b1;
      end else begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run, all compared against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_npc;

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .CLK(clk), .RST(rst), .pc_en(pc_en), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .ibus(bus),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_npc(ifid_npc)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: architectural PC, a queue standing in for the held word,
  // a halted flag and the instruction currently visible to ID.
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  logic        m_halted;
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_inpc;

  logic [129:0] act_vec;
  assign act_vec = {bus.iREN, bus.iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc};

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [129:0] exp_vec();
    logic want_req;
    want_req = !m_halted && (m_held.size() == 0);
    return {want_req, m_pc, m_v, m_instr, m_ipc, m_inpc};
  endfunction

  task automatic model_bubble();
    m_v     = 1'b0;
    m_instr = NOP;
  endtask

  task automatic model_update();
    logic        fetching;
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'h0;
      m_held.delete();
      m_halted = 1'b0;
      m_v = 1'b0;
      m_instr = NOP;
      m_ipc = 32'h0;
      m_inpc = 32'h0;
    end else if (!m_halted) begin
      fetching = (m_held.size() == 0) && bus.ihit;
      if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_held.delete();
        model_bubble();
      end else if (halt) begin
        m_halted = 1'b1;
        m_held.delete();
        model_bubble();
      end else if (flush_ifid || stall_ifid || !pc_en) begin
        if (flush_ifid) model_bubble();
        if (fetching) m_held.push_back(bus.iload);
      end else if (m_held.size() > 0 || fetching) begin
        w = (m_held.size() > 0) ? m_held.pop_front() : bus.iload;
        m_v = 1'b1;
        m_instr = w;
        m_ipc = m_pc;
        m_inpc = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
      end else begin
        model_bubble();
      end
    end
  endtask

  // Apply one cycle of inputs; the icache returns the word for the model's PC.
  task automatic drive(input logic r, input logic pe, input logic st, input logic fl,
                       input logic rv, input logic [31:0] rp, input logic h, input logic ih);
    rst = r; pc_en = pe; stall_ifid = st; flush_ifid = fl;
    redirect_valid = rv; redirect_pc = rp; halt = h;
    bus.ihit = ih;
    bus.iload = ih ? mem(m_pc) : $urandom();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
    tick();
    tick();
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL reset_model: got %h expected %h", act_vec, exp_vec());
    end
    checks++;
    if ({bus.iREN, bus.iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h0}) begin
      errors++; $display("[TB] FAIL reset_values: got %h expected %h", act_vec,
                         {1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h0});
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 32'h0, 0, 1);
      tick();
      checks++;
      if (ifid_pc !== 32'(i * 4) || ifid_valid !== 1'b1 || bus.iREN !== 1'b1) begin
        errors++; $display("[TB] FAIL stream_pc%0d: got pc=%h v=%b ren=%b expected pc=%h v=1 ren=1",
                           i, ifid_pc, ifid_valid, bus.iREN, 32'(i * 4));
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("[TB] FAIL stream_model: got %h expected %h", act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_stall_hold();
    drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0, 32'h0, 0, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 32'h0, 0, 1);
      tick();
      checks++;
      if (bus.iREN !== 1'b0 || ifid_pc !== 32'h4 || bus.iaddr !== 32'h8 || ifid_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_hold: got ren=%b ifid_pc=%h iaddr=%h v=%b expected 0 4 8 1",
                           bus.iREN, ifid_pc, bus.iaddr, ifid_valid);
      end
    end
    drive(0, 1, 0, 0, 0, 32'h0, 0, 0);
    tick();
    checks++;
    if (ifid_pc !== 32'h8 || bus.iaddr !== 32'hC || ifid_instr !== mem(32'h8) || bus.iREN !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release: got pc=%h iaddr=%h instr=%h ren=%b expected 8 c %h 1",
                         ifid_pc, bus.iaddr, ifid_instr, bus.iREN, mem(32'h8));
    end
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL stall_model: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_redirect_hold();
    drive(0, 1, 1, 0, 0, 32'h0, 0, 1);
    tick();
    drive(0, 1, 0, 0, 1, 32'h41, 0, 1);
    tick();
    checks++;
    if (ifid_valid !== 1'b0 || bus.iaddr !== 32'h40 || bus.iREN !== 1'b1) begin
      errors++; $display("[TB] FAIL redirect_hold: got v=%b iaddr=%h ren=%b expected 0 40 1",
                         ifid_valid, bus.iaddr, bus.iREN);
    end
    drive(0, 1, 0, 0, 0, 32'h0, 0, 1);
    tick();
    checks++;
    if (ifid_pc !== 32'h40 || ifid_instr !== mem(32'h40) || ifid_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL redirect_target: got pc=%h instr=%h v=%b expected 40 %h 1",
                         ifid_pc, ifid_instr, ifid_valid, mem(32'h40));
    end
  endtask

  task automatic test_flush_buffer();
    drive(0, 1, 0, 0, 1, 32'h10, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 32'h0, 0, 1);
    tick();
    checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== NOP || bus.iaddr !== 32'h10 || bus.iREN !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_bubble: got v=%b instr=%h iaddr=%h ren=%b expected 0 %h 10 0",
                         ifid_valid, ifid_instr, bus.iaddr, bus.iREN, NOP);
    end
    drive(0, 1, 0, 0, 0, 32'h0, 0, 0);
    tick();
    checks++;
    if (ifid_pc !== 32'h10 || ifid_instr !== mem(32'h10) || ifid_valid !== 1'b1 || bus.iaddr !== 32'h14) begin
      errors++; $display("[TB] FAIL flush_issue: got pc=%h instr=%h v=%b iaddr=%h expected 10 %h 1 14",
                         ifid_pc, ifid_instr, ifid_valid, bus.iaddr, mem(32'h10));
    end
  endtask

  task automatic test_miss();
    drive(0, 1, 0, 0, 1, 32'h20, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 32'h0, 0, 0);
      tick();
      checks++;
      if (ifid_valid !== 1'b0 || bus.iaddr !== 32'h20 || bus.iREN !== 1'b1) begin
        errors++; $display("[TB] FAIL miss_bubble%0d: got v=%b iaddr=%h ren=%b expected 0 20 1",
                           i, ifid_valid, bus.iaddr, bus.iREN);
      end
    end
    drive(0, 1, 0, 0, 0, 32'h0, 0, 1);
    tick();
    checks++;
    if (ifid_pc !== 32'h20 || ifid_npc !== 32'h24 || ifid_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL miss_hit: got pc=%h npc=%h v=%b expected 20 24 1",
                         ifid_pc, ifid_npc, ifid_valid);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 32'h0, 0, 1);
    tick();
    checks++;
    if (ifid_pc !== 32'hFFFF_FFFC || ifid_npc !== 32'h0 || bus.iaddr !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap: got pc=%h npc=%h iaddr=%h expected fffffffc 0 0",
                         ifid_pc, ifid_npc, bus.iaddr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    drive(0, 1, 0, 0, 0, 32'h0, 1, 1);
    tick();
    frozen = bus.iaddr;
    checks++;
    if (ifid_valid !== 1'b0 || bus.iREN !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_enter: got v=%b ren=%b expected 0 0", ifid_valid, bus.iREN);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
            $urandom(), 1'($urandom()), 1'($urandom()));
      tick();
      checks++;
      if (ifid_valid !== 1'b0 || bus.iREN !== 1'b0 || bus.iaddr !== frozen) begin
        errors++; $display("[TB] FAIL halt_stay%0d: got v=%b ren=%b iaddr=%h expected 0 0 %h",
                           i, ifid_valid, bus.iREN, bus.iaddr, frozen);
      end
    end
    drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
    tick();
    checks++;
    if (bus.iaddr !== 32'h0 || bus.iREN !== 1'b1 || ifid_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_reset: got iaddr=%h ren=%b v=%b expected 0 1 0",
                         bus.iaddr, bus.iREN, ifid_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(199) == 0), ($urandom_range(5) != 0), ($urandom_range(4) == 0),
            ($urandom_range(7) == 0), ($urandom_range(9) == 0), $urandom(),
            ($urandom_range(149) == 0), ($urandom_range(2) != 0));
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    m_pc = 32'h0; m_halted = 1'b0; m_v = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_inpc = 32'h0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_hold();
    test_flush_buffer();
    test_miss();
    test_wrap();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
